// File: rtl/cc_gate_seq.sv
// Registered gating-command sequencer: IDLE -> EVAL -> DRIVE, holding the decoded gate vector for HOLD_CYC cycles.
// Optional grant counter is built only when CC_GATE_CNT_EN is defined; otherwise grant_cnt is tied to zero.
module cc_gate_seq #(
  parameter int NCH      = 8,
  parameter int HOLD_CYC = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_i,
  input  logic           cmd_k,
  input  logic           cmd_q,
  input  logic           cmd_p,
  input  logic           cmd_m,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] inhibit,
  input  logic           abort,
  output logic [NCH-1:0] gate,
  output logic           gate_valid,
  output logic           busy,
  output logic [15:0]    grant_cnt
);

  localparam int CW = $clog2(HOLD_CYC + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EVAL  = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  logic [1:0]     state;
  logic [CW-1:0]  hold_cnt;
  logic           lat_i, lat_k, lat_q, lat_p, lat_m;
  logic [NCH-1:0] lat_req, lat_inh;
  logic           arm, fire;
  logic [NCH-1:0] nxt;

  // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both high.
  assign cmd_ready = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE);

  always_comb begin
    arm  = lat_i & lat_k & ~lat_q;
    fire = lat_i & lat_k & lat_q & ~lat_p;
    nxt  = '0;
    if (lat_m) begin
      if (arm)       nxt = lat_req & ~lat_inh;
      else if (fire) nxt = ~lat_inh;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      gate       <= '0;
      gate_valid <= 1'b0;
      lat_i      <= 1'b0;
      lat_k      <= 1'b0;
      lat_q      <= 1'b0;
      lat_p      <= 1'b0;
      lat_m      <= 1'b0;
      lat_req    <= '0;
      lat_inh    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            lat_i   <= cmd_i;
            lat_k   <= cmd_k;
            lat_q   <= cmd_q;
            lat_p   <= cmd_p;
            lat_m   <= cmd_m;
            lat_req <= req;
            lat_inh <= inhibit;
            state   <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (nxt != '0) begin
            gate       <= nxt;
            gate_valid <= 1'b1;
            hold_cnt   <= HOLD_LOAD;
            state      <= S_DRIVE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DRIVE: begin
          // abort wins over a counter that still has cycles left
          if (abort || hold_cnt == '0) begin
            gate       <= '0;
            gate_valid <= 1'b0;
            hold_cnt   <= '0;
            state      <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt - CNT_ONE;
          end
        end
        default: begin
          gate       <= '0;
          gate_valid <= 1'b0;
          hold_cnt   <= '0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CC_GATE_CNT_EN
  logic [15:0] grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= 16'h0000;
    end else if (state == S_EVAL && nxt != '0) begin
      grant_q <= grant_q + 16'h0001;
    end
  end

  assign grant_cnt = grant_q;
`else
  assign grant_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cc_gate_seq.sv
// Bench for cc_gate_seq: directed scenarios then random commands, checked against a timeline model of the command rules.
module tb_cc_gate_seq;

  localparam int NCH = 8;
  localparam int H   = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_i, cmd_k, cmd_q, cmd_p, cmd_m;
  logic [NCH-1:0] req, inhibit;
  logic           abort;
  logic [NCH-1:0] gate;
  logic           gate_valid;
  logic           busy;
  logic [15:0]    grant_cnt;

  cc_gate_seq #(.NCH(NCH), .HOLD_CYC(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_i      (cmd_i),
    .cmd_k      (cmd_k),
    .cmd_q      (cmd_q),
    .cmd_p      (cmd_p),
    .cmd_m      (cmd_m),
    .req        (req),
    .inhibit    (inhibit),
    .abort      (abort),
    .gate       (gate),
    .gate_valid (gate_valid),
    .busy       (busy),
    .grant_cnt  (grant_cnt)
  );

  // scoreboard
  int             checks = 0;
  int             errors = 0;
  int             exp_cnt = 0;
  logic [NCH-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH-1:0] ref_gate(input logic i, input logic k, input logic q,
                                              input logic p, input logic m,
                                              input logic [NCH-1:0] r, input logic [NCH-1:0] inh);
    if (!m) return '0;
    if (i && k && !q) return r & ~inh;
    if (i && k && q && !p) return ~inh;
    return '0;
  endfunction

  // driver tasks
  task automatic scramble();
    cmd_i   = 1'($urandom_range(0, 1));
    cmd_k   = 1'($urandom_range(0, 1));
    cmd_q   = 1'($urandom_range(0, 1));
    cmd_p   = 1'($urandom_range(0, 1));
    cmd_m   = 1'($urandom_range(0, 1));
    req     = NCH'($urandom);
    inhibit = NCH'($urandom);
  endtask

  task automatic issue(input logic i, input logic k, input logic q, input logic p, input logic m,
                       input logic [NCH-1:0] r, input logic [NCH-1:0] inh);
    chk("idle_ready", 32'(cmd_ready), 1);
    cmd_i = i; cmd_k = k; cmd_q = q; cmd_p = p; cmd_m = m;
    req = r; inhibit = inh;
    cmd_valid = 1'b1;
    abort = 1'($urandom_range(0, 1));
    exp_q.push_back(ref_gate(i, k, q, p, m, r, inh));
    @(negedge clk);
    cmd_valid = 1'b0;
    scramble();
    abort = 1'($urandom_range(0, 1));
    chk("eval_busy", 32'(busy), 1);
    chk("eval_ready", 32'(cmd_ready), 0);
    chk("eval_gate_valid", 32'(gate_valid), 0);
  endtask

  task automatic finish_cmd(input int abort_at);
    logic [NCH-1:0] g;
    int n;
    g = exp_q.pop_front();
    @(negedge clk);
    abort = 1'b0;
    if (g == '0) begin
      chk("null_gate_valid", 32'(gate_valid), 0);
      chk("null_gate", 32'(gate), 0);
      chk("null_busy", 32'(busy), 0);
      chk("null_ready", 32'(cmd_ready), 1);
    end else begin
`ifdef CC_GATE_CNT_EN
      exp_cnt = (exp_cnt + 1) & 32'hFFFF;
`endif
      n = (abort_at >= 1 && abort_at <= H) ? abort_at : H;
      for (int c = 1; c <= n; c++) begin
        if (c > 1) @(negedge clk);
        chk("drive_gate_valid", 32'(gate_valid), 1);
        chk("drive_gate", 32'(gate), 32'(g));
        chk("drive_ready", 32'(cmd_ready), 0);
        scramble();
        abort = (c == n && abort_at != 0) ? 1'b1 : 1'b0;
      end
      @(negedge clk);
      abort = 1'b0;
      chk("end_gate_valid", 32'(gate_valid), 0);
      chk("end_gate", 32'(gate), 0);
      chk("end_busy", 32'(busy), 0);
      chk("end_ready", 32'(cmd_ready), 1);
    end
    chk("grant_cnt", 32'(grant_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int ab;
    logic [NCH-1:0] g;
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_i = 1'b0; cmd_k = 1'b0; cmd_q = 1'b0; cmd_p = 1'b0; cmd_m = 1'b0;
    req = '0; inhibit = '0;
    repeat (2) @(negedge clk);
    chk("rst_gate", 32'(gate), 0);
    chk("rst_gate_valid", 32'(gate_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_grant_cnt", 32'(grant_cnt), 0);
    rst = 1'b0;
    @(negedge clk);

    // arm: F0 & ~30 = C0
    issue(1, 1, 0, 0, 1, 8'hF0, 8'h30);
    finish_cmd(0);
    // fire: ~01 = FE, back to back
    issue(1, 1, 1, 0, 1, NCH'($urandom), 8'h01);
    finish_cmd(0);
    // null commands
    issue(1, 1, 0, 0, 0, 8'hFF, 8'h00);
    finish_cmd(0);
    issue(1, 1, 1, 1, 1, 8'hFF, 8'h00);
    finish_cmd(0);
    issue(1, 1, 0, 0, 1, 8'h0F, 8'h0F);
    finish_cmd(0);
    // abort on 2nd DRIVE cycle, then immediate next command
    issue(1, 1, 0, 0, 1, 8'hFF, 8'h00);
    finish_cmd(2);
    issue(1, 1, 1, 0, 1, 8'h00, 8'hAA);
    finish_cmd(0);
    issue(1, 1, 1, 0, 1, 8'h00, 8'h00);
    finish_cmd(1);

    // reset mid-DRIVE with gate = FF
    issue(1, 1, 1, 0, 1, 8'h00, 8'h00);
    g = exp_q.pop_front();
    @(negedge clk);
    chk("t1_gate_pre", 32'(gate), 32'(g));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t1_gate", 32'(gate), 0);
    chk("t1_gate_valid", 32'(gate_valid), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_ready", 32'(cmd_ready), 0);
    chk("t1_grant_cnt", 32'(grant_cnt), 0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_ready_after", 32'(cmd_ready), 1);
    chk("t1_gate_after", 32'(gate), 0);

    // random commands, biased toward arm/fire
    for (int t = 0; t < 80; t++) begin
      logic ri, rk, rq, rp, rm;
      ri = 1'($urandom_range(0, 7) != 0);
      rk = 1'($urandom_range(0, 7) != 0);
      rq = 1'($urandom_range(0, 1));
      rp = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 5) != 0);
      ab = $urandom_range(0, H + 2);
      if (ab > H) ab = 0;
      issue(ri, rk, rq, rp, rm, NCH'($urandom), NCH'($urandom));
      finish_cmd(ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
